// File: rtl/dyse_run_pkg.sv
// Shared types and helpers for the inhibitor run sequencer: FSM state encoding
// and the per-run LFSR seed derivation.
package dyse_run_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DP_RST   = 3'd1,
    LOAD_INH = 3'd2,
    START    = 3'd3,
    RUN      = 3'd4,
    EMIT     = 3'd5,
    FIN      = 3'd6
  } run_state_e;

  localparam logic [63:0] SEED_NONZERO = 64'h1;

  // An all-zero seed would lock up the datapath LFSR, so it is replaced.
  function automatic logic [63:0] next_seed(input logic [63:0] base, input logic [63:0] idx);
    logic [63:0] sum;
    sum = base + idx;
    return (sum == 64'h0) ? SEED_NONZERO : sum;
  endfunction

endpackage

// File: rtl/inh_list_walker.sv
// Holds the batch inhibitor list and steps through it one entry per cycle,
// flagging the final entry and an empty list.
module inh_list_walker #(
  parameter int MAX_INH   = 8,
  parameter int LOG_RULES = 4,
  parameter int CNT_W     = $clog2(MAX_INH + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic [MAX_INH*LOG_RULES-1:0] list_in,
  input  logic [CNT_W-1:0]             count_in,
  input  logic                         restart,
  input  logic                         advance,
  output logic [LOG_RULES-1:0]         sel,
  output logic                         last,
  output logic                         empty
);

  localparam int IDX_W = (MAX_INH > 1) ? $clog2(MAX_INH) : 1;

  logic [MAX_INH*LOG_RULES-1:0] list_q, list_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [IDX_W-1:0]             idx_q, idx_d;

  assign sel   = list_q[idx_q*LOG_RULES +: LOG_RULES];
  assign empty = (count_q == '0);
  assign last  = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

  always_comb begin
    list_d  = list_q;
    count_d = count_q;
    idx_d   = idx_q;
    if (load) begin
      list_d  = list_in;
      count_d = (count_in > CNT_W'(MAX_INH)) ? CNT_W'(MAX_INH) : count_in;
      idx_d   = '0;
    end else if (restart) begin
      idx_d = '0;
    end else if (advance && !last) begin
      idx_d = idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      list_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
    end else begin
      list_q  <= list_d;
      count_q <= count_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/inhibit_run_sequencer.sv
// Batch controller for the asynchronous network datapath: per run it resets the
// datapath, reloads inhibitors, seeds and starts it, then returns the final state.
module inhibit_run_sequencer
  import dyse_run_pkg::*;
#(
  parameter int RULES     = 16,
  parameter int LOG_RULES = 4,
  parameter int LOG_ITER  = 8,
  parameter int MAX_INH   = 8,
  parameter int LOG_RUNS  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [63:0]                  cfg_base_seed,
  input  logic [LOG_RUNS-1:0]          cfg_num_runs,
  input  logic [$clog2(MAX_INH+1)-1:0] cfg_inh_count,
  input  logic [MAX_INH*LOG_RULES-1:0] cfg_inh_list,
  output logic                         dp_rst,
  output logic                         dp_start,
  output logic                         dp_ld_inhibitor,
  output logic [LOG_RULES-1:0]         dp_sel_inhibitor,
  output logic [63:0]                  dp_seed,
  input  logic [RULES-1:0]             dp_network_state,
  input  logic                         dp_steady_state,
  input  logic [LOG_ITER-1:0]          dp_iteration_number,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [RULES-1:0]             res_state,
  output logic [LOG_ITER-1:0]          res_iter,
  output logic                         res_steady,
  output logic [LOG_RUNS-1:0]          res_run_idx,
  output logic                         busy,
  output logic                         done
);

  localparam int CNT_W = $clog2(MAX_INH + 1);

  run_state_e          state_q, state_d;
  logic [LOG_RUNS-1:0] run_idx_q, run_idx_d;
  logic [LOG_RUNS-1:0] num_runs_q, num_runs_d;
  logic [63:0]         base_seed_q, base_seed_d;
  logic [63:0]         seed_q, seed_d;
  logic                settle_q, settle_d;
  logic                res_valid_q, res_valid_d;
  logic [RULES-1:0]    res_state_q, res_state_d;
  logic [LOG_ITER-1:0] res_iter_q, res_iter_d;
  logic                res_steady_q, res_steady_d;
  logic [LOG_RUNS-1:0] res_run_idx_q, res_run_idx_d;

  logic                 cfg_hs;
  logic                 iter_max;
  logic [LOG_RULES-1:0] inh_sel;
  logic                 inh_last;
  logic                 inh_empty;

  assign cfg_hs   = cfg_valid && (state_q == IDLE);
  assign iter_max = (dp_iteration_number == '1);

  inh_list_walker #(
    .MAX_INH   (MAX_INH),
    .LOG_RULES (LOG_RULES),
    .CNT_W     (CNT_W)
  ) u_walker (
    .clk      (clk),
    .rst      (rst),
    .load     (cfg_hs),
    .list_in  (cfg_inh_list),
    .count_in (cfg_inh_count),
    .restart  (state_q == DP_RST),
    .advance  (state_q == LOAD_INH),
    .sel      (inh_sel),
    .last     (inh_last),
    .empty    (inh_empty)
  );

  always_comb begin
    state_d       = state_q;
    run_idx_d     = run_idx_q;
    num_runs_d    = num_runs_q;
    base_seed_d   = base_seed_q;
    seed_d        = seed_q;
    settle_d      = settle_q;
    res_valid_d   = res_valid_q;
    res_state_d   = res_state_q;
    res_iter_d    = res_iter_q;
    res_steady_d  = res_steady_q;
    res_run_idx_d = res_run_idx_q;
    case (state_q)
      IDLE: begin
        if (cfg_hs) begin
          num_runs_d  = cfg_num_runs;
          base_seed_d = cfg_base_seed;
          run_idx_d   = '0;
          seed_d      = next_seed(cfg_base_seed, 64'd0);
          state_d     = (cfg_num_runs == '0) ? FIN : DP_RST;
        end
      end
      DP_RST:   state_d = inh_empty ? START : LOAD_INH;
      LOAD_INH: if (inh_last) state_d = START;
      START: begin
        settle_d = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        // Status inputs are stale on the first RUN cycle, so they are skipped once.
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (dp_steady_state || iter_max) begin
          res_state_d   = dp_network_state;
          res_iter_d    = dp_iteration_number;
          res_steady_d  = dp_steady_state;
          res_run_idx_d = run_idx_q;
          res_valid_d   = 1'b1;
          state_d       = EMIT;
        end
      end
      EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (run_idx_q == (num_runs_q - LOG_RUNS'(1))) begin
            state_d = FIN;
          end else begin
            run_idx_d = run_idx_q + LOG_RUNS'(1);
            seed_d    = next_seed(base_seed_q, 64'(run_idx_q) + 64'd1);
            state_d   = DP_RST;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      run_idx_q     <= '0;
      num_runs_q    <= '0;
      base_seed_q   <= '0;
      seed_q        <= '0;
      settle_q      <= 1'b0;
      res_valid_q   <= 1'b0;
      res_state_q   <= '0;
      res_iter_q    <= '0;
      res_steady_q  <= 1'b0;
      res_run_idx_q <= '0;
    end else begin
      state_q       <= state_d;
      run_idx_q     <= run_idx_d;
      num_runs_q    <= num_runs_d;
      base_seed_q   <= base_seed_d;
      seed_q        <= seed_d;
      settle_q      <= settle_d;
      res_valid_q   <= res_valid_d;
      res_state_q   <= res_state_d;
      res_iter_q    <= res_iter_d;
      res_steady_q  <= res_steady_d;
      res_run_idx_q <= res_run_idx_d;
    end
  end

  assign cfg_ready        = (state_q == IDLE);
  assign dp_rst           = (state_q == IDLE) || (state_q == DP_RST);
  assign dp_start         = (state_q == START);
  assign dp_ld_inhibitor  = (state_q == LOAD_INH);
  assign dp_sel_inhibitor = dp_ld_inhibitor ? inh_sel : '0;
  assign dp_seed          = seed_q;
  assign res_valid        = res_valid_q;
  assign res_state        = res_state_q;
  assign res_iter         = res_iter_q;
  assign res_steady       = res_steady_q;
  assign res_run_idx      = res_run_idx_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == FIN);

endmodule

// File: tb/tb_inhibit_run_sequencer.sv
// Directed bench for inhibit_run_sequencer with a small behavioural datapath that
// counts iterations after start and reports steady state at a chosen iteration.
module tb_inhibit_run_sequencer;

  localparam int RULES = 16, LOG_RULES = 4, LOG_ITER = 8, MAX_INH = 8, LOG_RUNS = 16;

  logic                         clk, rst;
  logic                         cfg_valid, cfg_ready;
  logic [63:0]                  cfg_base_seed;
  logic [LOG_RUNS-1:0]          cfg_num_runs;
  logic [3:0]                   cfg_inh_count;
  logic [MAX_INH*LOG_RULES-1:0] cfg_inh_list;
  logic                         dp_rst, dp_start, dp_ld_inhibitor;
  logic [LOG_RULES-1:0]         dp_sel_inhibitor;
  logic [63:0]                  dp_seed;
  logic [RULES-1:0]             dp_network_state;
  logic                         dp_steady_state;
  logic [LOG_ITER-1:0]          dp_iteration_number;
  logic                         res_valid, res_ready;
  logic [RULES-1:0]             res_state;
  logic [LOG_ITER-1:0]          res_iter;
  logic                         res_steady;
  logic [LOG_RUNS-1:0]          res_run_idx;
  logic                         busy, done;

  inhibit_run_sequencer dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_base_seed(cfg_base_seed), .cfg_num_runs(cfg_num_runs),
    .cfg_inh_count(cfg_inh_count), .cfg_inh_list(cfg_inh_list),
    .dp_rst(dp_rst), .dp_start(dp_start), .dp_ld_inhibitor(dp_ld_inhibitor),
    .dp_sel_inhibitor(dp_sel_inhibitor), .dp_seed(dp_seed),
    .dp_network_state(dp_network_state), .dp_steady_state(dp_steady_state),
    .dp_iteration_number(dp_iteration_number), .res_valid(res_valid),
    .res_ready(res_ready), .res_state(res_state), .res_iter(res_iter),
    .res_steady(res_steady), .res_run_idx(res_run_idx), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath
  logic                running;
  logic [LOG_ITER-1:0] iter;
  logic                steady_en;
  logic [LOG_ITER-1:0] steady_tgt;

  always @(posedge clk) begin
    if (dp_rst) begin
      running <= 1'b0;
      iter    <= '0;
    end else if (dp_start) begin
      running <= 1'b1;
      iter    <= '0;
    end else if (running && iter != '1) begin
      iter <= iter + 1'b1;
    end
  end

  assign dp_iteration_number = iter;
  assign dp_network_state    = {~iter, iter};
  assign dp_steady_state     = running && steady_en && (iter == steady_tgt);

  // Observation
  typedef struct {
    logic [RULES-1:0]    st;
    logic [LOG_ITER-1:0] it;
    logic                sd;
    logic [LOG_RUNS-1:0] idx;
  } res_t;

  res_t                 rq[$];
  logic [63:0]          sq[$];
  logic [LOG_RULES-1:0] lq[$];
  int                   n_start, n_done;

  always @(negedge clk) begin
    if (rst) begin
      if (dp_rst && busy) sq.push_back(dp_seed);
      if (dp_ld_inhibitor) lq.push_back(dp_sel_inhibitor);
      if (dp_start) n_start++;
      if (done) n_done++;
      if (res_valid && res_ready) rq.push_back('{res_state, res_iter, res_steady, res_run_idx});
    end
  end

  int n_checks = 0, n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0]                  base;
    logic [LOG_RUNS-1:0]          runs;
    logic [3:0]                   cnt;
    logic [MAX_INH*LOG_RULES-1:0] list;
    logic                         sen;
    logic [LOG_ITER-1:0]          tgt;
    logic [63:0]                  seed0, seed1;
    logic [LOG_ITER-1:0]          eiter;
    logic                         esteady;
    logic [RULES-1:0]             estate;
    int                           eloads;
  } vec_t;

  vec_t vt[7];

  task automatic start_batch(input vec_t v);
    rq.delete(); sq.delete(); lq.delete();
    n_start = 0; n_done = 0;
    steady_en  = v.sen;
    steady_tgt = v.tgt;
    @(posedge clk); #1;
    cfg_base_seed = v.base; cfg_num_runs = v.runs;
    cfg_inh_count = v.cnt;  cfg_inh_list = v.list;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000 && n_done == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({name, "_done_count"}, 64'(n_done), 64'd1);
  endtask

  task automatic wait_neg(input string name, input int which);
    int seen;
    seen = 0;
    for (int i = 0; i < 1000 && seen == 0; i++) begin
      @(negedge clk);
      if (which == 0) seen = int'(dp_ld_inhibitor);
      else if (which == 1) seen = int'(dp_start);
      else seen = int'(res_valid);
    end
    if (seen == 0) chk({name, "_wait_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int nl;
    start_batch(v);
    wait_done(name);
    chk({name, "_n_results"}, 64'(rq.size()), 64'(v.runs));
    for (int i = 0; i < rq.size(); i++) begin
      chk({name, "_run_idx"}, 64'(rq[i].idx), 64'(i));
      chk({name, "_iter"},    64'(rq[i].it),  64'(v.eiter));
      chk({name, "_steady"},  64'(rq[i].sd),  64'(v.esteady));
      chk({name, "_state"},   64'(rq[i].st),  64'(v.estate));
    end
    chk({name, "_n_seeds"}, 64'(sq.size()), 64'(v.runs));
    if (sq.size() > 0) chk({name, "_seed0"}, sq[0], v.seed0);
    if (sq.size() > 1) chk({name, "_seed1"}, sq[1], v.seed1);
    nl = v.eloads * int'(v.runs);
    chk({name, "_n_loads"}, 64'(lq.size()), 64'(nl));
    for (int k = 0; k < lq.size() && k < nl; k++)
      chk({name, "_sel"}, 64'(lq[k]), 64'(v.list[(k % v.eloads)*LOG_RULES +: LOG_RULES]));
    chk({name, "_n_start"}, 64'(n_start), 64'(v.runs));
  endtask

  initial begin
    res_t snap;
    int   bad, st0, dn0;

    vt[0] = '{base:64'h5, runs:2, cnt:2, list:32'h73, sen:1, tgt:10,
              seed0:64'h5, seed1:64'h6, eiter:10, esteady:1, estate:16'hF50A, eloads:2};
    vt[1] = '{base:64'hFFFF_FFFF_FFFF_FFFF, runs:2, cnt:0, list:0, sen:1, tgt:10,
              seed0:64'hFFFF_FFFF_FFFF_FFFF, seed1:64'h1, eiter:10, esteady:1, estate:16'hF50A, eloads:0};
    vt[2] = '{base:64'h100, runs:1, cnt:0, list:0, sen:0, tgt:10,
              seed0:64'h100, seed1:64'h0, eiter:8'hFF, esteady:0, estate:16'h00FF, eloads:0};
    vt[3] = '{base:64'h20, runs:1, cnt:1, list:32'h9, sen:1, tgt:8'hFF,
              seed0:64'h20, seed1:64'h0, eiter:8'hFF, esteady:1, estate:16'h00FF, eloads:1};
    vt[4] = '{base:64'h30, runs:1, cnt:9, list:32'h8765_4321, sen:1, tgt:10,
              seed0:64'h30, seed1:64'h0, eiter:10, esteady:1, estate:16'hF50A, eloads:8};
    vt[5] = '{base:64'h40, runs:0, cnt:2, list:32'h22, sen:1, tgt:10,
              seed0:64'h0, seed1:64'h0, eiter:0, esteady:0, estate:16'h0, eloads:2};
    vt[6] = '{base:64'h0, runs:2, cnt:2, list:32'h22, sen:1, tgt:10,
              seed0:64'h1, seed1:64'h1, eiter:10, esteady:1, estate:16'hF50A, eloads:2};

    rst = 1'b0; cfg_valid = 1'b0; res_ready = 1'b1;
    cfg_base_seed = '0; cfg_num_runs = '0; cfg_inh_count = '0; cfg_inh_list = '0;
    steady_en = 1'b0; steady_tgt = '0; n_start = 0; n_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_dp_rst",    64'(dp_rst),    64'd1);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_done",      64'(done),      64'd0);
    chk("rst_dp_seed",   dp_seed,        64'd0);
    chk("rst_dp_start",  64'(dp_start),  64'd0);

    for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Backpressure: result held while res_ready is low, next run follows handshake.
    res_ready = 1'b0;
    start_batch(vt[0]);
    wait_neg("bp", 2);
    snap = '{res_state, res_iter, res_steady, res_run_idx};
    st0  = n_start;
    bad  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!res_valid || res_state !== snap.st || res_iter !== snap.it ||
          res_steady !== snap.sd || res_run_idx !== snap.idx) bad++;
    end
    chk("bp_res_stable", 64'(bad), 64'd0);
    chk("bp_no_start",   64'(n_start), 64'(st0));
    @(posedge clk); #1 res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_next_dp_rst", 64'(dp_rst && busy), 64'd1);
    chk("bp_valid_drop",  64'(res_valid), 64'd0);
    wait_done("bp");
    chk("bp_n_results", 64'(rq.size()), 64'd2);

    // Reset during LOAD_INH
    start_batch(vt[0]);
    wait_neg("rst_ld", 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_ld_busy",      64'(busy), 64'd0);
    chk("rst_ld_res_valid", 64'(res_valid), 64'd0);
    chk("rst_ld_ld",        64'(dp_ld_inhibitor), 64'd0);
    rst = 1'b1;
    dn0 = n_done;
    repeat (5) @(negedge clk);
    chk("rst_ld_no_done", 64'(n_done), 64'(dn0));

    // Reset during RUN
    start_batch(vt[0]);
    wait_neg("rst_run", 1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_run_busy",      64'(busy), 64'd0);
    chk("rst_run_res_valid", 64'(res_valid), 64'd0);
    chk("rst_run_cfg_ready", 64'(cfg_ready), 64'd1);
    rst = 1'b1;
    dn0 = n_done;
    repeat (20) @(negedge clk);
    chk("rst_run_no_done",   64'(n_done), 64'(dn0));
    chk("rst_run_no_result", 64'(rq.size()), 64'd0);

    run_vec(vt[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
